load_store_unit: RTL and testbench

Initiator side of the data-memory port in the multi-cycle processor. Accepts one load, store, push or pop request at a time from the datapath control FSM and sequences the memory's address, write-data, MemWr and MemRd signals. Captures read data and owns the stack pointer. Range-checks every access against the data and stack segments; a failing check returns an error response without touching memory.

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/stack_pointer.sv | 52 +++++
 rtl/load_store_unit.sv | 199 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op encodings, FSM states,
// word widths and the default data/stack segment bounds (the data memory
// uses the same segment constants).
package lsu_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned OP_W   = 2;

    localparam logic [OP_W-1:0] OP_LW   = 2'b00;
    localparam logic [OP_W-1:0] OP_SW   = 2'b01;
    localparam logic [OP_W-1:0] OP_PUSH = 2'b10;
    localparam logic [OP_W-1:0] OP_POP  = 2'b11;

    localparam int unsigned DEF_DATA_SEG_START  = 0;
    localparam int unsigned DEF_DATA_SEG_END    = 255;
    localparam int unsigned DEF_STACK_SEG_START = 256;
    localparam int unsigned DEF_STACK_SEG_END   = 511;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_SETUP,
        ST_RD_CAPTURE,
        ST_WR,
        ST_RESP
    } lsu_state_e;

endpackage

// File: rtl/stack_pointer.sv
// Stack pointer register for a downward-growing stack.
// Ports:
//   clk, rst_n  - clock, async active-low reset (sp resets to SEG_END+1, empty)
//   inc_i       - pop completed: sp += 1
//   dec_i       - push completed: sp -= 1
//   sp_o        - current stack pointer (points at last pushed word)
//   full_c_o    - combinational: sp == SEG_START
//   empty_c_o   - combinational: sp == SEG_END+1
module stack_pointer
    import lsu_pkg::*;
#(
    parameter int unsigned SEG_START = DEF_STACK_SEG_START,
    parameter int unsigned SEG_END   = DEF_STACK_SEG_END
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_i,
    input  logic              dec_i,
    output logic [WORD_W-1:0] sp_o,
    output logic              full_c_o,
    output logic              empty_c_o
);

    localparam logic [WORD_W-1:0] SP_RESET = WORD_W'(SEG_END) + WORD_W'(1);
    localparam logic [WORD_W-1:0] SP_FULL  = WORD_W'(SEG_START);

    logic [WORD_W-1:0] sp_q;
    logic [WORD_W-1:0] sp_d;

    // Increment and decrement are never requested together by the FSM.
    always_comb begin
        sp_d = sp_q;
        if (inc_i) begin
            sp_d = sp_q + WORD_W'(1);
        end else if (dec_i) begin
            sp_d = sp_q - WORD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= SP_RESET;
        end else begin
            sp_q <= sp_d;
        end
    end

    assign sp_o      = sp_q;
    assign full_c_o  = (sp_q == SP_FULL);
    assign empty_c_o = (sp_q == SP_RESET);

endmodule

// File: rtl/load_store_unit.sv
// Initiator side of the data-memory port. Accepts one LW/SW/PUSH/POP at a
// time, range-checks it, sequences registered memory strobes, captures read
// data and owns the stack pointer.
// Ports:
//   clk, rst_n                    - clock, async active-low reset
//   req_valid/ready/op/addr/wdata - request handshake (ready only in IDLE)
//   rsp_valid/err/rdata           - one-cycle response pulse with status/data
//   mem_address/data_in/MemWr/MemRd - registered memory strobes
//   mem_data_out                  - combinational memory read data
//   sp                            - current stack pointer
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_SEG_START  = DEF_DATA_SEG_START,
    parameter int unsigned DATA_SEG_END    = DEF_DATA_SEG_END,
    parameter int unsigned STACK_SEG_START = DEF_STACK_SEG_START,
    parameter int unsigned STACK_SEG_END   = DEF_STACK_SEG_END
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic [WORD_W-1:0] mem_address,
    output logic [WORD_W-1:0] mem_data_in,
    output logic              mem_MemWr,
    output logic              mem_MemRd,
    input  logic [WORD_W-1:0] mem_data_out,
    output logic [WORD_W-1:0] sp
);

    localparam logic [WORD_W-1:0] DATA_BASE = WORD_W'(DATA_SEG_START);
    localparam logic [WORD_W-1:0] DATA_SPAN = WORD_W'(DATA_SEG_END - DATA_SEG_START);

    lsu_state_e        state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [WORD_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [WORD_W-1:0] mem_address_q, mem_address_d;
    logic [WORD_W-1:0] mem_data_in_q, mem_data_in_d;
    logic              mem_wr_q, mem_wr_d;
    logic              mem_rd_q, mem_rd_d;

    logic              sp_inc_c;
    logic              sp_dec_c;
    logic              sp_full_c;
    logic              sp_empty_c;
    logic [WORD_W-1:0] sp_val;
    logic              addr_ok_c;

    stack_pointer #(
        .SEG_START (STACK_SEG_START),
        .SEG_END   (STACK_SEG_END)
    ) u_stack_pointer (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_i     (sp_inc_c),
        .dec_i     (sp_dec_c),
        .sp_o      (sp_val),
        .full_c_o  (sp_full_c),
        .empty_c_o (sp_empty_c)
    );

    // Offset-from-base compare: addresses below the base wrap to huge values.
    assign addr_ok_c = ((req_addr - DATA_BASE) <= DATA_SPAN);

    // Next state and next registered outputs; outputs align with the state
    // they are loaded alongside.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        rsp_err_d     = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        mem_address_d = '0;
        mem_data_in_d = '0;
        mem_wr_d      = 1'b0;
        mem_rd_d      = 1'b0;
        sp_inc_c      = 1'b0;
        sp_dec_c      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d = req_op;
                    // Error path is the default; legal ops override it below.
                    state_d     = ST_RESP;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    case (req_op)
                        OP_LW: begin
                            if (addr_ok_c) begin
                                state_d       = ST_RD_SETUP;
                                rsp_err_d     = 1'b0;
                                rsp_rdata_d   = rsp_rdata_q;
                                mem_address_d = req_addr;
                                mem_rd_d      = 1'b1;
                            end
                        end
                        OP_SW: begin
                            if (addr_ok_c) begin
                                state_d       = ST_WR;
                                rsp_err_d     = 1'b0;
                                mem_address_d = req_addr;
                                mem_data_in_d = req_wdata;
                                mem_wr_d      = 1'b1;
                            end
                        end
                        OP_PUSH: begin
                            if (!sp_full_c) begin
                                state_d       = ST_WR;
                                rsp_err_d     = 1'b0;
                                mem_address_d = sp_val - WORD_W'(1);
                                mem_data_in_d = req_wdata;
                                mem_wr_d      = 1'b1;
                            end
                        end
                        default: begin // OP_POP
                            if (!sp_empty_c) begin
                                state_d       = ST_RD_SETUP;
                                rsp_err_d     = 1'b0;
                                rsp_rdata_d   = rsp_rdata_q;
                                mem_address_d = sp_val;
                                mem_rd_d      = 1'b1;
                            end
                        end
                    endcase
                end
            end
            ST_RD_SETUP: begin
                state_d       = ST_RD_CAPTURE;
                mem_address_d = mem_address_q;
                mem_rd_d      = 1'b1;
            end
            ST_RD_CAPTURE: begin
                state_d     = ST_RESP;
                rsp_rdata_d = mem_data_out;
                sp_inc_c    = (op_q == OP_POP);
            end
            ST_WR: begin
                state_d     = ST_RESP;
                rsp_rdata_d = '0;
                sp_dec_c    = (op_q == OP_PUSH);
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_LW;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_rdata_q   <= '0;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
            mem_wr_q      <= 1'b0;
            mem_rd_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_rdata_q   <= rsp_rdata_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
            mem_wr_q      <= mem_wr_d;
            mem_rd_q      <= mem_rd_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign mem_address = mem_address_q;
    assign mem_data_in = mem_data_in_q;
    assign mem_MemWr   = mem_wr_q;
    assign mem_MemRd   = mem_rd_q;
    assign sp          = sp_val;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;
    import lsu_pkg::*;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          n_wr;
        int          n_rd;
        logic [31:0] waddr;
        logic [31:0] sp_after;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_MemWr;
    logic        mem_MemRd;
    logic [31:0] mem_data_out;
    logic [31:0] sp;

    logic [31:0] ram [1024];
    logic [31:0] model_mem [1024];
    logic [31:0] model_sp;
    exp_t        sb_q [$];
    int          n_cmp;
    int          n_mis;

    load_store_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_rdata    (rsp_rdata),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_MemWr    (mem_MemWr),
        .mem_MemRd    (mem_MemRd),
        .mem_data_out (mem_data_out),
        .sp           (sp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_data_out = ram[mem_address[9:0]];
    always @(posedge clk) begin
        if (mem_MemWr) ram[mem_address[9:0]] <= mem_data_in;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference behaviour of one request; updates the model stack and memory.
    task automatic model_req(input logic [1:0] op, input logic [31:0] addr,
                             input logic [31:0] wdata, output exp_t e);
        e.err = 1'b0; e.rdata = '0; e.lat = 1; e.n_wr = 0; e.n_rd = 0; e.waddr = '0;
        case (op)
            OP_LW: begin
                if (addr > 32'd255) e.err = 1'b1;
                else begin e.rdata = model_mem[addr[9:0]]; e.lat = 3; e.n_rd = 2; end
            end
            OP_SW: begin
                if (addr > 32'd255) e.err = 1'b1;
                else begin
                    model_mem[addr[9:0]] = wdata; e.lat = 2; e.n_wr = 1; e.waddr = addr;
                end
            end
            OP_PUSH: begin
                if (model_sp == 32'd256) e.err = 1'b1;
                else begin
                    model_sp = model_sp - 32'd1;
                    model_mem[model_sp[9:0]] = wdata; e.lat = 2; e.n_wr = 1; e.waddr = model_sp;
                end
            end
            default: begin
                if (model_sp == 32'd512) e.err = 1'b1;
                else begin
                    e.rdata = model_mem[model_sp[9:0]]; model_sp = model_sp + 32'd1;
                    e.lat = 3; e.n_rd = 2;
                end
            end
        endcase
        e.sp_after = model_sp;
    endtask

    task automatic do_req(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        exp_t        got_e;
        bit          got;
        bit          rdy;
        logic [31:0] sp_seen;
        logic [31:0] ready_seen;
        model_req(op, addr, wdata, e);
        sb_q.push_back(e);
        rdy = 1'b0;
        for (int i = 0; i < 20 && !rdy; i++) begin
            @(negedge clk);
            rdy = req_ready;
        end
        if (!rdy) check_val("ready_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        got = 1'b0; got_e.n_wr = 0; got_e.n_rd = 0; got_e.waddr = '0; got_e.lat = 0;
        got_e.err = 1'b0; got_e.rdata = '0; sp_seen = '0; ready_seen = '0;
        for (int c = 1; c <= 10 && !got; c++) begin
            if (c > 1) @(negedge clk);
            if (mem_MemWr) begin got_e.n_wr++; got_e.waddr = mem_address; end
            if (mem_MemRd) got_e.n_rd++;
            if (rsp_valid) begin
                got = 1'b1; got_e.lat = c; got_e.err = rsp_err; got_e.rdata = rsp_rdata;
                sp_seen = sp; ready_seen = 32'(req_ready);
            end
        end
        e = sb_q.pop_front();
        if (!got) begin
            check_val("rsp_timeout", 32'd0, 32'd1);
        end else begin
            check_val("latency", 32'(got_e.lat), 32'(e.lat));
            check_val("rsp_err", 32'(got_e.err), 32'(e.err));
            check_val("rsp_rdata", got_e.rdata, e.rdata);
            check_val("wr_cycles", 32'(got_e.n_wr), 32'(e.n_wr));
            check_val("rd_cycles", 32'(got_e.n_rd), 32'(e.n_rd));
            if (e.n_wr != 0) check_val("wr_addr", got_e.waddr, e.waddr);
            check_val("sp_after", sp_seen, e.sp_after);
            check_val("ready_in_resp", ready_seen, 32'd0);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 1'b0;
        model_sp = 32'd512;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] bnd [4];
        int          seen_rsp;
        n_cmp = 0; n_mis = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        model_sp = 32'd512;
        for (int i = 0; i < 1024; i++) begin ram[i] = '0; model_mem[i] = '0; end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check_val("rst_sp", sp, 32'd512);
        check_val("rst_ready", 32'(req_ready), 32'd1);
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_rsp_rdata", rsp_rdata, 32'd0);
        check_val("rst_memwr", 32'(mem_MemWr), 32'd0);
        check_val("rst_memrd", 32'(mem_MemRd), 32'd0);
        check_val("rst_addr", mem_address, 32'd0);

        do_req(OP_SW, 32'd5, 32'hDEADBEEF);
        do_req(OP_LW, 32'd5, 32'h0);

        do_req(OP_PUSH, 32'd0, 32'h11);
        do_req(OP_PUSH, 32'd0, 32'h22);
        do_req(OP_POP, 32'd0, 32'h0);
        do_req(OP_POP, 32'd0, 32'h0);

        do_req(OP_POP, 32'd0, 32'h0);
        do_req(OP_LW, 32'd300, 32'h0);

        bnd[0] = 32'd0; bnd[1] = 32'd255; bnd[2] = 32'd256; bnd[3] = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            do_req(OP_SW, bnd[i], $urandom);
            do_req(OP_LW, bnd[i], 32'h0);
        end

        for (int i = 0; i < 256; i++) do_req(OP_PUSH, 32'd0, 32'(i) ^ 32'hA5A5_0000);
        check_val("full_sp", sp, 32'd256);
        do_req(OP_PUSH, 32'd0, 32'h1234_5678);
        do_req(OP_POP, 32'd0, 32'h0);

        // Reset in the middle of a PUSH write cycle.
        apply_reset();
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_PUSH; req_addr = '0; req_wdata = 32'h55;
        @(posedge clk);
        #1;
        check_val("wr_before_rst", 32'(mem_MemWr), 32'd1);
        #2;
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        check_val("wr_async_drop", 32'(mem_MemWr), 32'd0);
        check_val("addr_async_rst", mem_address, 32'd0);
        check_val("sp_async_rst", sp, 32'd512);
        @(negedge clk);
        rst_n = 1'b1;
        seen_rsp = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen_rsp++;
        end
        check_val("no_rsp_after_rst", 32'(seen_rsp), 32'd0);
        check_val("sp_after_rst", sp, 32'd512);
        check_val("ready_after_rst", 32'(req_ready), 32'd1);
        model_sp = 32'd512;
        do_req(OP_PUSH, 32'd0, 32'h77);
        do_req(OP_POP, 32'd0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
